hack_mem_arbiter: RTL
=====================

# hack_mem_arbiter

Two-port arbiter that shares the single Hack data-memory port (16-bit data, 15-bit address, RAM/screen/keyboard map) between the CPU and a DMA requester such as a screen-scan or block-copy engine. CPU has priority, bounded by a DMA starvation limit. Each cycle it performs at most one access, forwards the winner's address, data and write strobe to memory, and returns registered read data with a valid pulse. Writes to the read-only keyboard and unmapped regions are suppressed and flagged.

## Interface
- STARVE_MAX, 4: number of consecutive lost cycles a requesting DMA tolerates before it is forced to win. Legal range 1..15.
- CNT_W, 16: width of the conflict statistics counter.

- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests an access this cycle
- cpu_we  in  1  CPU access is a write
- cpu_addr  in  15  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle (combinational)
- cpu_rdata  out  16  registered read data for CPU
- cpu_rvalid  out  1  cpu_rdata valid; one-cycle pulse
- dma_req, dma_we, dma_addr[14:0], dma_wdata[15:0], dma_gnt, dma_rdata[15:0], dma_rvalid  same as CPU equivalents, for the DMA port
- mem_addr  out  15  address to memory
- mem_wdata  out  16  write data to memory
- mem_load  out  1  memory write enable
- mem_rdata  in  16  memory read data (combinational from mem_addr)
- wr_err  out  1  registered pulse: a granted write hit 0x6000..0x7FFF and was dropped
- conflict_cnt  out  CNT_W  saturating count of cycles in which both ports requested

## Operation
- Winner per cycle, combinational:
  - Neither requests: no grant.
  - Only one requests: that port wins.
  - Both request: DMA wins if starve == STARVE_MAX; otherwise CPU wins.
- starve counter, 4-bit:
  - Increments on a cycle where dma_req=1 and the CPU wins.
  - Clears on a DMA grant or when dma_req=0.
  - Never exceeds STARVE_MAX.
- Memory mux:
  - mem_addr and mem_wdata come from the winner. With no winner they hold the CPU inputs and mem_load=0.
  - mem_load = winner_we AND NOT (mem_addr >= 0x6000).
- Writes to 0x6000..0x7FFF (keyboard and unmapped):
  - Still granted.
  - mem_load stays 0.
  - wr_err pulses the next cycle.
- Reads:
  - On a granted read, mem_rdata is captured at the rising edge into the winner's rdata register, and that port's rvalid pulses for the following cycle.
  - The loser's rdata register holds its previous value.
  - A granted write produces no rvalid.
- conflict_cnt increments on every cycle with cpu_req && dma_req and saturates at all-ones.
- Requesters must hold req, we, addr and wdata stable until they see gnt. Dropping req before gnt is legal: the access is abandoned and no state changes.

## Timing
- Grant and memory-side outputs are combinational from the request inputs: zero-cycle arbitration, one access per cycle.
- Read latency: data and rvalid appear 1 cycle after the grant cycle.
- Back-to-back grants to the same port are allowed every cycle.
- Worst-case DMA wait with continuous CPU traffic is STARVE_MAX cycles. The DMA is granted on cycle STARVE_MAX+1 after its request, then the CPU resumes.
- While reset=1:
  - cpu_gnt, dma_gnt and mem_load are forced to 0.
  - mem_addr = 0 and mem_wdata = 0.
  - starve = 0 and conflict_cnt = 0.
  - cpu_rdata and dma_rdata = 0; cpu_rvalid, dma_rvalid and wr_err = 0.
- Reset asserted mid-access: the grant and write are suppressed immediately, and no rvalid follows after reset is released.
- First cycle after reset release: normal arbitration with starve = 0.
- Simultaneous DMA grant with starve == STARVE_MAX: starve clears in the same edge; no extra DMA slot.

## Test plan
- Isolated accesses: CPU writes 0x1234 to 0x0010, then CPU reads 0x0010 -> cpu_gnt=1 in both cycles, mem_load=1 only on the write, cpu_rdata=0x1234 with cpu_rvalid one cycle after the read grant; dma_gnt stays 0.
- Contention with STARVE_MAX=4: cpu_req and dma_req both held high for 10 cycles -> grant pattern CPU,CPU,CPU,CPU,DMA,CPU,CPU,CPU,CPU,DMA; conflict_cnt=10.
- Protected write: DMA writes 0xFFFF to 0x6000 -> dma_gnt=1, mem_load=0, wr_err pulses next cycle, memory at 0x6000 unchanged.
- Mixed read: DMA reads screen address 0x4000 (preloaded 0xAAAA) while CPU is idle, CPU reads the same address the next cycle -> dma_rdata=0xAAAA then cpu_rdata=0xAAAA, each with its own one-cycle rvalid.
- Reset mid-stream: assert reset asynchronously during a CPU write cycle -> mem_load drops to 0 without waiting for a clock edge, starve=0, conflict_cnt=0; after release, a single DMA request is granted in the first cycle.
- Saturation with CNT_W=4: 20 contended cycles -> conflict_cnt stops at 15.

Source files
------------

// File: rtl/hack_mem_arbiter_if.sv
// Bus bundle between the Hack data-memory arbiter, its two requesters
// (CPU and DMA) and the single shared memory port.
interface hack_mem_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [14:0]      cpu_addr;
  logic [15:0]      cpu_wdata;
  logic             cpu_gnt;
  logic [15:0]      cpu_rdata;
  logic             cpu_rvalid;

  logic             dma_req;
  logic             dma_we;
  logic [14:0]      dma_addr;
  logic [15:0]      dma_wdata;
  logic             dma_gnt;
  logic [15:0]      dma_rdata;
  logic             dma_rvalid;

  logic [14:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic             mem_load;
  logic [15:0]      mem_rdata;

  logic             wr_err;
  logic [CNT_W-1:0] conflict_cnt;

  // Requester and memory side: drives requests and memory read data.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_load,
    output mem_rdata,
    input  wr_err, conflict_cnt
  );

  // Arbiter side: takes requests, drives grants and the memory port.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_load,
    input  mem_rdata,
    output wr_err, conflict_cnt
  );
endinterface

// File: rtl/hack_mem_arbiter.sv
// Shares the single Hack data-memory port between the CPU and a DMA engine.
// CPU has priority; a waiting DMA is forced through after STARVE_MAX lost
// cycles. Writes into the keyboard/unmapped region 0x6000..0x7FFF are granted
// but dropped, and flagged one cycle later on wr_err.
// STARVE_MAX must lie in 1..15 so that it fits the 4-bit starve counter.
module hack_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input logic               clock,
  input logic               reset,
  hack_mem_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]       r_starve;
  logic [CNT_W-1:0] r_conflictCnt;
  logic [15:0]      r_cpuRdata;
  logic [15:0]      r_dmaRdata;
  logic             r_cpuRvalid;
  logic             r_dmaRvalid;
  logic             r_wrErr;

  logic             w_cpuGnt;
  logic             w_dmaGnt;
  logic             w_winWe;
  logic [14:0]      w_memAddr;
  logic [15:0]      w_memWdata;
  logic             w_protHit;
  logic             w_memLoad;
  logic             w_conflict;

  assign w_conflict = bus.cpu_req & bus.dma_req;

  // Pick this cycle's winner; CPU first unless the DMA has starved long enough.
  always_comb begin
    w_cpuGnt = 1'b0;
    w_dmaGnt = 1'b0;
    if (!reset) begin
      if (w_conflict) begin
        if (r_starve == STARVE_LIM) begin
          w_dmaGnt = 1'b1;
        end else begin
          w_cpuGnt = 1'b1;
        end
      end else if (bus.cpu_req) begin
        w_cpuGnt = 1'b1;
      end else if (bus.dma_req) begin
        w_dmaGnt = 1'b1;
      end
    end
  end

  // Steer the winner onto the memory port; idle cycles park on the CPU inputs.
  always_comb begin
    w_memAddr  = bus.cpu_addr;
    w_memWdata = bus.cpu_wdata;
    w_winWe    = 1'b0;
    if (reset) begin
      w_memAddr  = 15'h0000;
      w_memWdata = 16'h0000;
    end else if (w_dmaGnt) begin
      w_memAddr  = bus.dma_addr;
      w_memWdata = bus.dma_wdata;
      w_winWe    = bus.dma_we;
    end else if (w_cpuGnt) begin
      w_winWe    = bus.cpu_we;
    end
  end

  assign w_protHit = (w_memAddr[14:13] == 2'b11);
  assign w_memLoad = w_winWe & ~w_protHit;

  // Count consecutive cycles a requesting DMA loses to the CPU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (w_dmaGnt || !bus.dma_req) begin
      r_starve <= 4'd0;
    end else if (w_cpuGnt && r_starve < STARVE_LIM) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Saturating count of cycles in which both ports wanted the memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_conflictCnt <= '0;
    end else if (w_conflict && r_conflictCnt != '1) begin
      r_conflictCnt <= r_conflictCnt + CNT_W'(1);
    end
  end

  // Capture read data for whichever port won a read; the other port holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cpuRdata  <= 16'h0000;
      r_dmaRdata  <= 16'h0000;
      r_cpuRvalid <= 1'b0;
      r_dmaRvalid <= 1'b0;
    end else begin
      r_cpuRvalid <= w_cpuGnt & ~bus.cpu_we;
      r_dmaRvalid <= w_dmaGnt & ~bus.dma_we;
      if (w_cpuGnt && !bus.cpu_we) begin
        r_cpuRdata <= bus.mem_rdata;
      end
      if (w_dmaGnt && !bus.dma_we) begin
        r_dmaRdata <= bus.mem_rdata;
      end
    end
  end

  // Flag a granted write that was dropped because it hit the protected region.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrErr <= 1'b0;
    end else begin
      r_wrErr <= w_winWe & w_protHit;
    end
  end

  assign bus.cpu_gnt      = w_cpuGnt;
  assign bus.dma_gnt      = w_dmaGnt;
  assign bus.mem_addr     = w_memAddr;
  assign bus.mem_wdata    = w_memWdata;
  assign bus.mem_load     = w_memLoad;
  assign bus.cpu_rdata    = r_cpuRdata;
  assign bus.dma_rdata    = r_dmaRdata;
  assign bus.cpu_rvalid   = r_cpuRvalid;
  assign bus.dma_rvalid   = r_dmaRvalid;
  assign bus.wr_err       = r_wrErr;
  assign bus.conflict_cnt = r_conflictCnt;

endmodule
